sdram_stream_engine: RTL
========================

SDRAM_STREAM_ENGINE -- requirements
Module: sdram_stream_engine

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning number of stream channels (1..4).
REQ-002 SHALL have parameter BURST_LEN, default 8, meaning SDRAM words per base burst.
REQ-003 SHALL have parameter CH_MULT, default {8'd16,8'd1}, meaning packed per-channel burst multiplier; channel c transfers CH_MULT[c]*BURST_LEN words per grant.
REQ-004 SHALL have parameter CH_BASE, default {22'h20000,22'h0}, meaning packed per-channel region base word address.
REQ-005 SHALL have parameter CH_SIZE, default {22'd1536000,22'd96000}, meaning packed per-channel region size in words; each size is a multiple of that channel's grant length.
REQ-006 SHALL have parameter ARB_RR, default 1, meaning 1 = round-robin arbitration, 0 = fixed priority with channel 0 highest.
REQ-007 SHALL have port i_Clk, input, 1, meaning the single clock domain of the block.
REQ-008 SHALL have port i_Reset, input, 1, meaning synchronous active-high reset.
REQ-009 SHALL have port i_SDRAM_Requested, input, 1, meaning another master wants the SDRAM.
REQ-010 SHALL have port o_SDRAM_Yield, output, 1, meaning the bus is released to the other master.
REQ-011 SHALL have port o_Command, output, 2, meaning 00 idle, 01 read, 10 write.
REQ-012 SHALL have port o_Data_Address, output, 22, meaning current SDRAM word address.
REQ-013 SHALL have port i_Data_Read_Valid, input, 1, meaning one read word is present on i_Data_Read.
REQ-014 SHALL have port i_Data_Write_Done, input, 1, meaning one write word has been accepted.
REQ-015 SHALL have port i_Data_Read, input, 32, meaning SDRAM read data; it is broadcast to all channels.
REQ-016 SHALL have port o_Data_Write, output, 32, meaning the write word of the granted channel.
REQ-017 SHALL have port i_Rd_Empty, input, NUM_CH, meaning a channel's readout FIFO is empty.
REQ-018 SHALL have port i_Wb_Empty, input, NUM_CH, meaning a channel's writeback FIFO is empty.
REQ-019 SHALL have port i_Wb_Full, input, NUM_CH, meaning a channel's writeback FIFO holds a full grant.
REQ-020 SHALL have port i_Wb_Data, input, 32*NUM_CH, meaning packed writeback FIFO heads.
REQ-021 SHALL have port o_Rd_Wrreq, output, NUM_CH, meaning write strobe into a channel's readout FIFO.
REQ-022 SHALL have port o_Wb_Rdreq, output, NUM_CH, meaning read-acknowledge strobe to a channel's writeback FIFO.
REQ-023 SHALL have port o_Grant_Ch, output, 2, meaning the index of the channel being served.

Function
REQ-024 SHALL implement states IDLE, READ and WRITE; o_Command SHALL be 00 in IDLE, 01 in READ and 10 in WRITE.
REQ-025 SHALL make channel c write-eligible when i_Wb_Full[c]=1, and read-eligible when i_Rd_Empty[c]=1 and i_Wb_Empty[c]=1; when both hold, write wins.
REQ-026 SHALL, in IDLE with i_SDRAM_Requested=0 and at least one eligible channel, select a winner and enter READ or WRITE on the next edge; with ARB_RR=1 the search starts at the channel after the last granted one.
REQ-027 SHALL, on each grant, latch o_Grant_Ch, load o_Data_Address with that channel's cursor, and load the beat counter with CH_MULT*BURST_LEN-1.
REQ-028 SHALL, in READ, pulse o_Rd_Wrreq[grant] combinationally with i_Data_Read_Valid; each beat increments the address and decrements the counter.
REQ-029 SHALL, in WRITE, drive o_Data_Write from i_Wb_Data[grant] and pulse o_Wb_Rdreq[grant] combinationally with i_Data_Write_Done; each beat increments the address and decrements the counter.
REQ-030 SHALL return to IDLE on the edge where a beat occurs with the counter at 0; the block SHALL spend at least one cycle in IDLE between grants.
REQ-031 SHALL leave the cursor unchanged after a READ grant; the following WRITE of the same region reuses it.
REQ-032 SHALL, after a WRITE grant, advance the cursor by the grant length, or wrap it to CH_BASE when cursor+length equals CH_BASE+CH_SIZE.
REQ-033 SHALL drive o_SDRAM_Yield = i_SDRAM_Requested AND state==IDLE; a request raised mid-burst SHALL NOT abort the burst.
REQ-034 SHALL give i_SDRAM_Requested priority over any grant when both occur in the same IDLE cycle.
REQ-035 SHALL drive all strobes to 0 outside their own state and for channels other than the granted one.

Reset
REQ-036 SHALL, while i_Reset=1 at an edge, set state IDLE, o_Command 00, o_Data_Address 0, o_Grant_Ch 0, cursors to CH_BASE, round-robin pointer to the last channel, and counter 0.
REQ-037 SHALL, on reset mid-burst, abandon the burst without advancing any cursor; no strobe SHALL pulse while i_Reset=1.

Verification
REQ-038 Bench SHALL cover: after reset, all Rd_Empty=1 and Wb_Empty=1 -> READ ch0 at addr 0x0, 8 Rd_Wrreq pulses, then IDLE.
REQ-039 Bench SHALL cover: ch1 read-eligible -> 128 beats starting at 0x20000 with o_Grant_Ch=1.
REQ-040 Bench SHALL cover: ch0 Wb_Full with the cursor at 95992 -> write to 95992..95999, then cursor wraps to 0.
REQ-041 Bench SHALL cover: ARB_RR=1 with both channels continuously eligible -> grants alternate 0,1,0,1; ARB_RR=0 -> ch0 always wins.
REQ-042 Bench SHALL cover: SDRAM_Requested asserted at beat 3 of a write -> burst completes, then Yield=1 and no new grant until the request drops.
REQ-043 Bench SHALL cover: reset asserted at beat 4 of a ch0 write -> IDLE next cycle, cursor ch0 = 0, o_Command 00.

Source files
------------

// File: rtl/sdram_stream_engine.sv
// sdram_stream_engine
//   Time-shares one SDRAM port between NUM_CH stream channels. Each grant
//   moves CH_MULT[c]*BURST_LEN words: a READ fills the channel's readout FIFO
//   from the channel cursor, and a WRITE drains the writeback FIFO back to the
//   same words and then advances the cursor, wrapping at the region end.
//   The bus is handed to another master only from IDLE.
//
// Ports
//   i_Clk, i_Reset         clock, synchronous active-high reset
//   i_SDRAM_Requested      another master wants the bus
//   o_SDRAM_Yield          bus released (request seen while IDLE)
//   o_Command              00 idle, 01 read, 10 write
//   o_Data_Address         current SDRAM word address
//   i_Data_Read_Valid      one read beat on i_Data_Read
//   i_Data_Write_Done      one write beat accepted
//   i_Data_Read            read data, broadcast to every channel
//   o_Data_Write           write word from the granted channel
//   i_Rd_Empty, i_Wb_Empty, i_Wb_Full   per-channel FIFO status
//   i_Wb_Data              packed writeback FIFO heads (32 bits per channel)
//   o_Rd_Wrreq, o_Wb_Rdreq per-channel FIFO strobes
//   o_Grant_Ch             channel being served
module sdram_stream_engine #(
  parameter int unsigned          NUM_CH    = 2,
  parameter int unsigned          BURST_LEN = 8,
  parameter logic [8*NUM_CH-1:0]  CH_MULT   = {8'd16, 8'd1},
  parameter logic [22*NUM_CH-1:0] CH_BASE   = {22'h20000, 22'h0},
  parameter logic [22*NUM_CH-1:0] CH_SIZE   = {22'd1536000, 22'd96000},
  parameter int unsigned          ARB_RR    = 1
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  input  logic                 i_SDRAM_Requested,
  output logic                 o_SDRAM_Yield,
  output logic [1:0]           o_Command,
  output logic [21:0]          o_Data_Address,
  input  logic                 i_Data_Read_Valid,
  input  logic                 i_Data_Write_Done,
  input  logic [31:0]          i_Data_Read,
  output logic [31:0]          o_Data_Write,
  input  logic [NUM_CH-1:0]    i_Rd_Empty,
  input  logic [NUM_CH-1:0]    i_Wb_Empty,
  input  logic [NUM_CH-1:0]    i_Wb_Full,
  input  logic [32*NUM_CH-1:0] i_Wb_Data,
  output logic [NUM_CH-1:0]    o_Rd_Wrreq,
  output logic [NUM_CH-1:0]    o_Wb_Rdreq,
  output logic [1:0]           o_Grant_Ch
);

  localparam int unsigned CNT_W = $clog2(255 * BURST_LEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       grant;
  logic [1:0]       rr_last;
  logic [21:0]      addr;
  logic [CNT_W-1:0] count;
  logic [21:0]      cursor [4];

  // Per-channel constants widened to four slots so every lookup is indexed
  // by the 2-bit channel number; unused slots read as zero.
  logic [21:0]      base_tbl [4];
  logic [21:0]      end_tbl  [4];
  logic [21:0]      len_tbl  [4];
  logic [CNT_W-1:0] last_tbl [4];
  logic [31:0]      wb_word  [4];

  for (genvar c = 0; c < 4; c++) begin : g_tbl
    if (c < NUM_CH) begin : g_on
      localparam int unsigned LEN = int'(CH_MULT[8*c +: 8]) * BURST_LEN;
      assign base_tbl[c] = CH_BASE[22*c +: 22];
      assign end_tbl[c]  = CH_BASE[22*c +: 22] + CH_SIZE[22*c +: 22];
      assign len_tbl[c]  = 22'(LEN);
      assign last_tbl[c] = CNT_W'(LEN - 1);
      assign wb_word[c]  = i_Wb_Data[32*c +: 32];
    end else begin : g_off
      assign base_tbl[c] = '0;
      assign end_tbl[c]  = '0;
      assign len_tbl[c]  = '0;
      assign last_tbl[c] = '0;
      assign wb_word[c]  = '0;
    end
  end

  logic [3:0]  wr_elig, rd_elig;
  logic        found;
  logic [1:0]  win;
  logic [1:0]  idx;
  int unsigned probe;

  always_comb begin
    wr_elig = '0;
    rd_elig = '0;
    wr_elig[NUM_CH-1:0] = i_Wb_Full;
    rd_elig[NUM_CH-1:0] = i_Rd_Empty & i_Wb_Empty;
  end

  // Round-robin search begins one past the last granted channel; fixed
  // priority always begins at channel 0. First eligible channel wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    probe = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (ARB_RR != 0) probe = (32'(rr_last) + 32'd1 + k) % NUM_CH;
      else             probe = k;
      idx = 2'(probe);
      if (!found && (wr_elig[idx] || rd_elig[idx])) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  logic start;
  logic beat;
  logic rd_fire, wr_fire;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    o_Command = 2'b00;
    rd_fire   = 1'b0;
    wr_fire   = 1'b0;
    case (state)
      S_IDLE: begin
        // An external request blocks any grant in the same cycle.
        if (!i_SDRAM_Requested && found) begin
          start     = 1'b1;
          state_nxt = wr_elig[win] ? S_WRITE : S_READ;
        end
      end
      S_READ: begin
        o_Command = 2'b01;
        rd_fire   = i_Data_Read_Valid;
        if (i_Data_Read_Valid && count == '0) state_nxt = S_IDLE;
      end
      S_WRITE: begin
        o_Command = 2'b10;
        wr_fire   = i_Data_Write_Done;
        if (i_Data_Write_Done && count == '0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign beat = rd_fire || wr_fire;

  logic [21:0] cur_sum;
  assign cur_sum = cursor[grant] + len_tbl[grant];

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state   <= S_IDLE;
      grant   <= '0;
      rr_last <= 2'(NUM_CH - 1);
      addr    <= '0;
      count   <= '0;
      cursor  <= base_tbl;
    end else begin
      state <= state_nxt;
      if (start) begin
        grant   <= win;
        rr_last <= win;
        addr    <= cursor[win];
        count   <= last_tbl[win];
      end else if (beat) begin
        addr  <= addr + 22'd1;
        count <= count - 1'b1;
        // Only a completed write consumes the region slot; a read leaves the
        // cursor so the matching write-back lands on the same words.
        if (wr_fire && count == '0)
          cursor[grant] <= (cur_sum == end_tbl[grant]) ? base_tbl[grant] : cur_sum;
      end
    end
  end

  assign o_SDRAM_Yield  = i_SDRAM_Requested && (state == S_IDLE);
  assign o_Data_Address = addr;
  assign o_Grant_Ch     = grant;
  assign o_Data_Write   = wb_word[grant];
  assign o_Rd_Wrreq     = (rd_fire && !i_Reset) ? (NUM_CH'(1) << grant) : '0;
  assign o_Wb_Rdreq     = (wr_fire && !i_Reset) ? (NUM_CH'(1) << grant) : '0;

  // i_Data_Read is routed to the FIFOs outside this block; it is listed here
  // only so the port set is complete.
  logic unused_read;
  assign unused_read = ^i_Data_Read;

endmodule
